key_conditioner: RTL
====================

// Module: key_conditioner
// PURPOSE
//   Front-end conditioner for a raw push-button pin; sits directly upstream of the
//   memory-mapped button peripheral and drives its active-low key input.
//   Synchronises the asynchronous pin, filters bounce, and generates press/release
//   pulses plus long-press (hold) and auto-repeat events for future bus registers.
// PARAMETERS
//   CLKRATE    25000000  clk frequency in Hz
//   SYNCSTAGES 2         synchroniser flops (>=2)
//   DBMSEC     20        debounce window, ms; DBCNT = CLKRATE/1000*DBMSEC (>=1)
//   HOLDMSEC   1000      press duration before hold, ms; HOLDCNT likewise (>DBCNT)
//   REPMSEC    200       auto-repeat period while held, ms; REPCNT likewise (>=1)
// PORTS
//   clk           in   1  system clock
//   nrst          in   1  asynchronous active-low reset
//   key_raw       in   1  pad input, active-low (0 = pressed), asynchronous
//   key_clean     out  1  debounced level, active-low; feeds button peripheral key
//   press_pulse   out  1  one-cycle pulse on confirmed press
//   release_pulse out  1  one-cycle pulse on confirmed release
//   hold          out  1  high from hold detection until confirmed release
//   repeat_pulse  out  1  one-cycle pulse at hold entry and every REPCNT cycles after
// BEHAVIOUR
//   - One clock, reset asynchronous active-low. Reset: key_clean=1, all pulses=0,
//     hold=0, sync chain=1 (released), state=IDLE, all counters=0.
//   - ks = last synchroniser stage; all decisions use ks only.
//   - Counters are unsigned, width $clog2(max count)+1; saturate, never wrap.
//   - FSM:
//     IDLE:       ks==0 -> PRESS_DB, dbcnt=1.
//     PRESS_DB:   ks==1 -> IDLE, dbcnt=0. ks==0 && dbcnt==DBCNT -> PRESSED:
//                 key_clean<=0, press_pulse<=1 for one cycle, holdcnt=0; else dbcnt++.
//     PRESSED:    holdcnt++ per cycle; holdcnt==HOLDCNT-1 -> HELD: hold<=1,
//                 repeat_pulse<=1, repcnt=0. ks==1 -> RELEASE_DB (wins over hold).
//     HELD:       repcnt++; repcnt==REPCNT-1 -> repeat_pulse<=1, repcnt=0.
//                 ks==1 -> RELEASE_DB (wins over repeat).
//     RELEASE_DB: holdcnt/repcnt frozen, no pulses. dbcnt counts consecutive ks==1;
//                 dbcnt==DBCNT -> IDLE: key_clean<=1, hold<=0, release_pulse<=1.
//                 ks==0 before that -> back to originating PRESSED/HELD (1-bit
//                 flag), counters resume, no pulses.
//   - Latency raw fall -> key_clean fall/press_pulse: SYNCSTAGES+DBCNT+1 cycles
//     for a clean edge; release symmetric.
//   - Bounce shorter than DBCNT samples never changes key_clean or emits a pulse.
//   - At most one of press/release/repeat pulses in any cycle. key_clean changes
//     only with press_pulse or release_pulse.
//   - Reset mid-press: outputs return to reset values immediately. A held key after
//     reset is re-debounced from IDLE and yields a fresh press_pulse.
// STRUCTURE
//   - key_cond_pkg: state enum {IDLE,PRESS_DB,PRESSED,HELD,RELEASE_DB} and
//     function ms_to_cycles(clkrate, ms).
//   - Sub-module sync_ff #(STAGES): reset-to-1 synchroniser chain.
//   - Top: FSM plus shared dbcnt and separate holdcnt/repcnt. Elaboration-time
//     $error if DBCNT<1, HOLDCNT<=DBCNT, or REPCNT<1.
// TESTING (CLKRATE=1000 -> 1 cycle/ms; DBMSEC=4, HOLDMSEC=20, REPMSEC=5,
//          SYNCSTAGES=2)
//   1 Reset held 3 cycles with key_raw=0, then release reset -> key_clean=1,
//     no pulses until IDLE re-debounce; press_pulse at cycle 7 after reset release.
//   2 Clean press 10 cycles, then release -> press_pulse 7 cycles after fall,
//     key_clean low 10 cycles, release_pulse 7 cycles after rise, hold never 1.
//   3 Bounce: 3-cycle low glitches separated by 1-cycle highs, repeated x5
//     -> key_clean stays 1, zero pulses.
//   4 Press 40 cycles -> hold rises 20 cycles after press_pulse, repeat_pulse at
//     hold entry and +5,+10,+15; on release, hold falls with release_pulse.
//   5 While HELD, 2-cycle high glitch -> no release_pulse, hold stays 1, next
//     repeat_pulse delayed by exactly 2 cycles (frozen counter).
//   6 Assert nrst mid-HELD -> same cycle key_clean=1, hold=0, all pulses 0,
//     no release_pulse emitted.

Source files
------------

// File: rtl/key_cond_pkg.sv
// rtl/key_cond_pkg.sv - shared state type and timing helper for the key conditioner
package key_cond_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        PRESSED    = 3'd2,
        HELD       = 3'd3,
        RELEASE_DB = 3'd4
    } key_state_t;

    // Converts a duration in milliseconds to a whole number of clk cycles.
    function automatic int ms_to_cycles(input int clkrate, input int ms);
        return (clkrate / 1000) * ms;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - reset-to-released synchroniser chain for an asynchronous pin
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic level,
    output logic synced
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_ff: STAGES must be at least 2");
    end

    logic [STAGES-1:0] chain;

    // Shift the pin through the chain; reset to 1 so the key reads as released.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], level};
        end
    end

    assign synced = chain[STAGES-1];

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - push-button synchroniser, debouncer and press/release/hold/repeat event generator
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int CLKRATE    = 25000000,
    parameter int SYNCSTAGES = 2,
    parameter int DBMSEC     = 20,
    parameter int HOLDMSEC   = 1000,
    parameter int REPMSEC    = 200
) (
    input  logic clk,
    input  logic nrst,
    input  logic key_raw,
    output logic key_clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold,
    output logic repeat_pulse
);

    localparam int DBCNT   = ms_to_cycles(CLKRATE, DBMSEC);
    localparam int HOLDCNT = ms_to_cycles(CLKRATE, HOLDMSEC);
    localparam int REPCNT  = ms_to_cycles(CLKRATE, REPMSEC);

    localparam int DB_W   = $clog2(DBCNT) + 1;
    localparam int HOLD_W = $clog2(HOLDCNT) + 1;
    localparam int REP_W  = $clog2(REPCNT) + 1;

    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DBCNT);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDCNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPCNT - 1);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

    if (DBCNT < 1) begin : g_bad_db
        $error("key_conditioner: debounce count must be at least 1");
    end
    if (HOLDCNT <= DBCNT) begin : g_bad_hold
        $error("key_conditioner: hold count must exceed debounce count");
    end
    if (REPCNT < 1) begin : g_bad_rep
        $error("key_conditioner: repeat count must be at least 1");
    end

    logic ks;

    sync_ff #(
        .STAGES (SYNCSTAGES)
    ) u_sync (
        .clk    (clk),
        .nrst   (nrst),
        .level  (key_raw),
        .synced (ks)
    );

    key_state_t        state, state_n;
    logic [DB_W-1:0]   dbcnt, dbcnt_n, db_inc;
    logic [HOLD_W-1:0] holdcnt, holdcnt_n, hold_inc;
    logic [REP_W-1:0]  repcnt, repcnt_n, rep_inc;
    logic              from_held, from_held_n;
    logic              key_clean_n, hold_n;
    logic              press_n, release_n, repeat_n;

    // Saturating increments. Hold and repeat counters stop one short of their
    // terminal value so a resume after an aborted release never skips an event;
    // the event then fires on the next steady-low cycle.
    assign db_inc   = (dbcnt == DB_MAX) ? dbcnt : dbcnt + DB_ONE;
    assign hold_inc = (holdcnt == HOLD_LAST) ? holdcnt : holdcnt + HOLD_ONE;
    assign rep_inc  = (repcnt == REP_LAST) ? repcnt : repcnt + REP_ONE;

    // Next-state, counter and output decisions, all driven from ks only.
    always_comb begin
        state_n     = state;
        dbcnt_n     = dbcnt;
        holdcnt_n   = holdcnt;
        repcnt_n    = repcnt;
        from_held_n = from_held;
        key_clean_n = key_clean;
        hold_n      = hold;
        press_n     = 1'b0;
        release_n   = 1'b0;
        repeat_n    = 1'b0;
        case (state)
            IDLE: begin
                if (!ks) begin
                    state_n = PRESS_DB;
                    dbcnt_n = DB_ONE;
                end
            end
            PRESS_DB: begin
                if (ks) begin
                    state_n = IDLE;
                    dbcnt_n = '0;
                end else if (dbcnt == DB_MAX) begin
                    state_n     = PRESSED;
                    dbcnt_n     = '0;
                    holdcnt_n   = '0;
                    key_clean_n = 1'b0;
                    press_n     = 1'b1;
                end else begin
                    dbcnt_n = db_inc;
                end
            end
            PRESSED: begin
                if (ks) begin
                    state_n     = RELEASE_DB;
                    dbcnt_n     = DB_ONE;
                    from_held_n = 1'b0;
                end else if (holdcnt == HOLD_LAST) begin
                    state_n  = HELD;
                    hold_n   = 1'b1;
                    repeat_n = 1'b1;
                    repcnt_n = '0;
                end else begin
                    holdcnt_n = hold_inc;
                end
            end
            HELD: begin
                if (ks) begin
                    state_n     = RELEASE_DB;
                    dbcnt_n     = DB_ONE;
                    from_held_n = 1'b1;
                end else if (repcnt == REP_LAST) begin
                    repeat_n = 1'b1;
                    repcnt_n = '0;
                end else begin
                    repcnt_n = rep_inc;
                end
            end
            RELEASE_DB: begin
                if (!ks) begin
                    // Release aborted: resume where we left off, counting this cycle.
                    dbcnt_n = '0;
                    if (from_held) begin
                        state_n  = HELD;
                        repcnt_n = rep_inc;
                    end else begin
                        state_n   = PRESSED;
                        holdcnt_n = hold_inc;
                    end
                end else if (dbcnt == DB_MAX) begin
                    state_n     = IDLE;
                    dbcnt_n     = '0;
                    holdcnt_n   = '0;
                    repcnt_n    = '0;
                    from_held_n = 1'b0;
                    key_clean_n = 1'b1;
                    hold_n      = 1'b0;
                    release_n   = 1'b1;
                end else begin
                    dbcnt_n = db_inc;
                end
            end
            default: begin
                state_n = IDLE;
                dbcnt_n = '0;
            end
        endcase
    end

    // State, counters and registered outputs; reset forces the released view.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            dbcnt         <= '0;
            holdcnt       <= '0;
            repcnt        <= '0;
            from_held     <= 1'b0;
            key_clean     <= 1'b1;
            hold          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_n;
            dbcnt         <= dbcnt_n;
            holdcnt       <= holdcnt_n;
            repcnt        <= repcnt_n;
            from_held     <= from_held_n;
            key_clean     <= key_clean_n;
            hold          <= hold_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            repeat_pulse  <= repeat_n;
        end
    end

endmodule
